// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two byte-stream requesters. Ownership
//   is held for a whole packet (up to and including the byte marked last),
//   with round-robin priority between packets and an idle timeout that
//   reclaims the transmitter if the owner or the transmitter stalls.
//
// Ports
//   clk, rst_n              system clock, async active-low reset
//   reqN_valid/data/last    requester N byte offer and end-of-packet marker
//   reqN_ready              accept strobe to requester N (combinational)
//   tx_data, tx_start       byte and one-cycle start pulse to the transmitter
//   tx_busy                 transmitter busy flag
//   grant                   one-hot owner marker (01 = req0, 10 = req1)
//   timeout_err             one-cycle pulse when a packet is aborted on timeout
//   busy                    high whenever the FSM is not idle
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no owner; arbitrate among valid requesters
// LOAD       | owner granted; waiting to accept its next byte
// START      | byte latched; tx_start asserted for this one cycle
// WAIT_BUSY  | waiting for the transmitter to raise tx_busy
// WAIT_DONE  | waiting for tx_busy to fall; then next byte or release

module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic [1:0] grant,
   output logic       timeout_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   localparam logic [21:0] CNT_LAST = 22'(TIMEOUT_CYCLES - 1);
   localparam logic [21:0] CNT_MAX  = '1;

   state_t      state_q;
   logic [1:0]  grant_q;
   logic        ptr_q;        // 0: req0 wins a tie, 1: req1 wins a tie
   logic [7:0]  tx_data_q;
   logic        last_q;
   logic [21:0] cnt_q;
   logic        tx_start_q;
   logic        timeout_err_q;
   logic        busy_q;

   logic [1:0]  win_d;
   logic        accept_d;
   logic [7:0]  acc_data_d;
   logic        acc_last_d;
   logic        cnt_hit_d;
   logic [21:0] cnt_d;

   always_comb begin
      win_d = 2'b00;
      if (req0_valid && req1_valid) begin
         win_d = ptr_q ? 2'b10 : 2'b01;
      end else if (req0_valid) begin
         win_d = 2'b01;
      end else if (req1_valid) begin
         win_d = 2'b10;
      end
   end

   assign req0_ready = (state_q == S_LOAD) && grant_q[0] && req0_valid;
   assign req1_ready = (state_q == S_LOAD) && grant_q[1] && req1_valid;
   assign accept_d   = req0_ready || req1_ready;
   assign acc_data_d = grant_q[1] ? req1_data : req0_data;
   assign acc_last_d = grant_q[1] ? req1_last : req0_last;

   // Saturating increment: the counter must never wrap back to zero.
   assign cnt_hit_d  = (cnt_q == CNT_LAST);
   assign cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 22'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         grant_q       <= 2'b00;
         ptr_q         <= 1'b0;
         tx_data_q     <= 8'h00;
         last_q        <= 1'b0;
         cnt_q         <= '0;
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (win_d != 2'b00) begin
                  grant_q <= win_d;
                  state_q <= S_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            S_LOAD: begin
               if (accept_d) begin
                  tx_data_q  <= acc_data_d;
                  last_q     <= acc_last_d;
                  tx_start_q <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= S_START;
               end else if (cnt_hit_d) begin
                  // Abort: the pointer moves to the side that did not own.
                  timeout_err_q <= 1'b1;
                  ptr_q         <= grant_q[0];
                  grant_q       <= 2'b00;
                  busy_q        <= 1'b0;
                  cnt_q         <= '0;
                  state_q       <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_START: begin
               cnt_q   <= '0;
               state_q <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (tx_busy) begin
                  cnt_q   <= '0;
                  state_q <= S_WAIT_DONE;
               end else if (cnt_hit_d) begin
                  timeout_err_q <= 1'b1;
                  ptr_q         <= grant_q[0];
                  grant_q       <= 2'b00;
                  busy_q        <= 1'b0;
                  cnt_q         <= '0;
                  state_q       <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_WAIT_DONE: begin
               cnt_q <= '0;
               if (!tx_busy) begin
                  if (last_q) begin
                     ptr_q   <= grant_q[0];
                     grant_q <= 2'b00;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_LOAD;
                  end
               end
            end
            default: begin
               grant_q <= 2'b00;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign grant       = grant_q;
   assign timeout_err = timeout_err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
   logic [7:0] d0 = 8'h00, d1 = 8'h00;
   logic       r0, r1;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy = 1'b0;
   logic [1:0] grant;
   logic       timeout_err;
   logic       busy;

   int compared = 0;
   int mismatched = 0;

   // Expected bytes per requester: {last, data}. Pushed at stimulus time.
   logic [8:0] exp0_q[$], exp1_q[$];
   logic [8:0] drv0_q[$], drv1_q[$];
   int         owner_log[$];

   bit stub_en = 1'b1;
   bit to_allowed = 1'b0;
   int busy_lo = 10, busy_hi = 10;
   bit mon_in_pkt = 1'b0;
   int mon_cur = 0;
   int n, bad;

   uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_data(d0), .req0_last(l0), .req0_ready(r0),
      .req1_valid(v1), .req1_data(d1), .req1_last(l1), .req1_ready(r1),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .grant(grant), .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   function automatic int log_code();
      int c = 0;
      foreach (owner_log[i]) c = c * 10 + owner_log[i] + 1;
      return c;
   endfunction

   task automatic add_byte(input int idx, input logic [7:0] b, input logic last);
      if (idx == 0) begin drv0_q.push_back({last, b}); exp0_q.push_back({last, b}); end
      else begin drv1_q.push_back({last, b}); exp1_q.push_back({last, b}); end
   endtask

   task automatic add_pkt(input int idx);
      int len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) add_byte(idx, 8'($urandom_range(0, 255)), (i == len - 1));
   endtask

   // Offers queued bytes of one requester, honouring ready, with random gaps.
   task automatic drive(input int idx, input int max_gap);
      logic [8:0] it;
      int w, g;
      while ((idx == 0 && drv0_q.size() > 0) || (idx == 1 && drv1_q.size() > 0)) begin
         if (idx == 0) begin it = drv0_q.pop_front(); d0 = it[7:0]; l0 = it[8]; v0 = 1'b1; end
         else begin it = drv1_q.pop_front(); d1 = it[7:0]; l1 = it[8]; v1 = 1'b1; end
         w = 0;
         forever begin
            @(negedge clk);
            if ((idx == 0 && r0) || (idx == 1 && r1)) break;
            w++;
            if (w >= 300) break;
         end
         if (w >= 300) fail_now($sformatf("req%0d_ready_wait", idx));
         @(posedge clk); #1;
         if (idx == 0) v0 = 1'b0; else v1 = 1'b0;
         g = int'($urandom_range(0, max_gap));
         if (g > 0) begin repeat (g) @(posedge clk); #1; end
      end
   endtask

   task automatic wait_ready0(input string name);
      int w = 0;
      do begin @(negedge clk); w++; end while (!r0 && w < 300);
      if (!r0) fail_now(name);
   endtask

   task automatic wait_tx_start(input string name);
      int w = 0;
      do begin @(negedge clk); w++; end while (!tx_start && w < 300);
      if (!tx_start) fail_now(name);
   endtask

   task automatic wait_txbusy(input logic lvl, input string name);
      int w = 0;
      do begin @(negedge clk); w++; end while (tx_busy != lvl && w < 300);
      if (tx_busy != lvl) fail_now(name);
   endtask

   task automatic wait_idle(input string name);
      int w = 0;
      do begin @(negedge clk); w++; end while ((busy || tx_busy) && w < 500);
      chk({name, "_idle"}, int'(busy), 0);
      chk({name, "_exp0_drained"}, exp0_q.size(), 0);
      chk({name, "_exp1_drained"}, exp1_q.size(), 0);
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      #1;
      chk({name, "_grant"}, int'(grant), 0);
      chk({name, "_tx_start"}, int'(tx_start), 0);
      chk({name, "_ready0"}, int'(r0), 0);
      chk({name, "_ready1"}, int'(r1), 0);
      chk({name, "_timeout_err"}, int'(timeout_err), 0);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_tx_data"}, int'(tx_data), 0);
      repeat (2) @(posedge clk);
      while (tx_busy) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Transmitter stub: raises tx_busy shortly after each start pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start && stub_en) begin
            repeat (1 + $urandom_range(0, 2)) @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat ($urandom_range(busy_lo, busy_hi)) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      logic [8:0] e;
      int own;
      forever begin
         @(negedge clk);
         if (!rst_n || timeout_err) mon_in_pkt = 1'b0;
         if (timeout_err && !to_allowed) chk("unexpected_timeout_err", 1, 0);
         if (r0 || r1)
            chk("ready_only_for_owner",
                int'((r0 && !r1 && grant == 2'b01) || (r1 && !r0 && grant == 2'b10)), 1);
         if (rst_n && tx_start) begin
            own = (grant == 2'b10) ? 1 : 0;
            chk("tx_grant_onehot", int'(grant == 2'b01 || grant == 2'b10), 1);
            if (mon_in_pkt) chk("packet_lock_owner", own, mon_cur);
            if ((own == 0 && exp0_q.size() == 0) || (own == 1 && exp1_q.size() == 0)) begin
               chk("unexpected_tx_start", 1, 0);
            end else begin
               if (own == 0) e = exp0_q.pop_front(); else e = exp1_q.pop_front();
               chk($sformatf("tx_data_req%0d", own), int'(tx_data), int'(e[7:0]));
               mon_in_pkt = !e[8];
               mon_cur = own;
               owner_log.push_back(own);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      do_reset("por");

      // Single packet 0x41, 0x42(last) with latency checks.
      busy_lo = 10; busy_hi = 10;
      exp0_q.push_back({1'b0, 8'h41});
      exp0_q.push_back({1'b1, 8'h42});
      v0 = 1'b1; d0 = 8'h41; l0 = 1'b0;
      @(negedge clk); chk("lat_grant_n", int'(grant), 0);
      @(negedge clk); chk("lat_grant_n1", int'(grant), 1); chk("lat_ready_n1", int'(r0), 1);
      @(posedge clk); #1 d0 = 8'h42; l0 = 1'b1;
      @(negedge clk); chk("lat_tx_start_n2", int'(tx_start), 1);
      bad = 0; n = 0;
      while (n < 300) begin
         @(negedge clk); n++;
         if (!busy) break;
         if (grant != 2'b01) bad++;
         if (r0 && v0) begin @(posedge clk); #1 v0 = 1'b0; end
      end
      chk("sp_grant_held", bad, 0);
      chk("sp_grant_clear", int'(grant), 0);
      wait_idle("sp");

      // Collision after reset: req0 (2 packets) vs req1 (1 packet).
      do_reset("col_rst");
      busy_lo = 2; busy_hi = 4;
      owner_log.delete();
      add_byte(0, 8'h10, 1'b0); add_byte(0, 8'h11, 1'b1); add_byte(0, 8'h30, 1'b1);
      add_byte(1, 8'h20, 1'b0); add_byte(1, 8'h21, 1'b1);
      fork
         drive(0, 0);
         drive(1, 0);
      join
      wait_idle("col");
      chk("col_order", log_code(), 11221);

      // Packet lock: req1 raises valid during req0's 3-byte packet.
      owner_log.delete();
      add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hA1, 1'b0); add_byte(0, 8'hA2, 1'b1);
      bad = 0;
      fork
         drive(0, 1);
         begin
            wait_tx_start("lock_first_start");
            add_byte(1, 8'hB0, 1'b1);
            drive(1, 0);
         end
         begin
            int w;
            w = 0;
            do begin @(negedge clk); w++; end while (!tx_start && w < 300);
            w = 0;
            forever begin
               @(negedge clk); w++;
               if (r1) bad++;
               if (!busy || w >= 400) break;
            end
            @(negedge clk);
            chk("lock_grant_after_idle", int'(grant), 2);
            chk("lock_ready1_after_idle", int'(r1), 1);
         end
      join
      wait_idle("lock");
      chk("lock_ready1_leak", bad, 0);
      chk("lock_order", log_code(), 1112);

      // Timeout in LOAD: non-last byte, then the owner goes silent.
      exp0_q.push_back({1'b0, 8'h55});
      @(posedge clk); #1 v0 = 1'b1; d0 = 8'h55; l0 = 1'b0;
      wait_ready0("to_accept");
      @(posedge clk); #1 v0 = 1'b0;
      to_allowed = 1'b1;
      wait_txbusy(1'b1, "to_busy_rise");
      wait_txbusy(1'b0, "to_busy_fall");
      n = 0;
      do begin @(negedge clk); n++; end while (!timeout_err && n < 100);
      chk("to_load_cycles", n, TO + 1);
      chk("to_grant", int'(grant), 0);
      chk("to_busy", int'(busy), 0);
      @(negedge clk);
      chk("to_pulse_width", int'(timeout_err), 0);
      to_allowed = 1'b0;
      owner_log.delete();
      add_byte(0, 8'h60, 1'b1); add_byte(1, 8'h61, 1'b1);
      fork
         drive(0, 0);
         drive(1, 0);
      join
      wait_idle("to_rr");
      chk("to_rr_order", log_code(), 21);

      // Stuck transmitter: tx_busy never rises.
      stub_en = 1'b0;
      to_allowed = 1'b1;
      exp0_q.push_back({1'b1, 8'h70});
      @(posedge clk); #1 v0 = 1'b1; d0 = 8'h70; l0 = 1'b1;
      wait_ready0("stuck_accept");
      @(posedge clk); #1 v0 = 1'b0;
      wait_tx_start("stuck_start");
      n = 0;
      do begin @(negedge clk); n++; end while (!timeout_err && n < 100);
      chk("stuck_wait_cycles", n, TO + 1);
      chk("stuck_busy", int'(busy), 0);
      chk("stuck_grant", int'(grant), 0);
      @(negedge clk);
      to_allowed = 1'b0;
      stub_en = 1'b1;

      // Reset during WAIT_DONE, then req0 must regain priority.
      busy_lo = 10; busy_hi = 10;
      exp0_q.push_back({1'b0, 8'h80});
      @(posedge clk); #1 v0 = 1'b1; d0 = 8'h80; l0 = 1'b0;
      wait_ready0("wd_accept");
      @(posedge clk); #1 v0 = 1'b0;
      wait_txbusy(1'b1, "wd_busy_rise");
      @(negedge clk); @(negedge clk);
      do_reset("wd_rst");
      busy_lo = 2; busy_hi = 4;
      owner_log.delete();
      add_byte(0, 8'h90, 1'b1); add_byte(1, 8'h91, 1'b1);
      fork
         drive(0, 0);
         drive(1, 0);
      join
      wait_idle("wd_rr");
      chk("wd_rr_order", log_code(), 12);

      // Randomized traffic from both requesters.
      busy_lo = 1; busy_hi = 4;
      for (int round = 0; round < 3; round++) begin
         for (int p = 0; p < 5; p++) begin
            add_pkt(0);
            add_pkt(1);
         end
         fork
            drive(0, 4);
            drive(1, 4);
         join
         wait_idle($sformatf("rand%0d", round));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 2700000, the mid-packet idle limit in clk cycles (100 ms at 27 MHz).
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each, meaning the requester presents a byte.
REQ-005 The block SHALL have ports req0_data / req1_data, input, 8 each, the byte to send.
REQ-006 The block SHALL have ports req0_last / req1_last, input, 1 each, marking the final byte of a packet.
REQ-007 The block SHALL have ports req0_ready / req1_ready, output, 1 each, the byte-accept strobe.
REQ-008 The block SHALL have port tx_data, output, 8, the byte driven to the UART transmitter.
REQ-009 The block SHALL have port tx_start, output, 1, a one-cycle start pulse to the transmitter.
REQ-010 The block SHALL have port tx_busy, input, 1, the transmitter-busy flag.
REQ-011 The block SHALL have port grant, output, 2, a one-hot marker of the current owner.
REQ-012 The block SHALL have port timeout_err, output, 1, a one-cycle abort pulse.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 The state machine SHALL have states IDLE, LOAD, START, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with any reqX_valid, the block SHALL register grant to the winner and move to LOAD on the next edge.
REQ-016 Round-robin SHALL apply: the priority pointer favours req0 after reset, and when both are valid the pointer side wins.
REQ-017 The pointer SHALL flip to the non-owner only when a packet completes or aborts.
REQ-018 In LOAD, reqX_ready SHALL be combinationally high only for the granted X with reqX_valid high.
REQ-019 On a LOAD accept, the block SHALL latch tx_data and reqX_last and go to START.
REQ-020 The non-granted requester SHALL be ignored, with ready held low and no effect on the datapath, until the owner's packet ends.
REQ-021 tx_start SHALL be high exactly during the START cycle, after which the state goes to WAIT_BUSY.
REQ-022 Latency: valid sampled in IDLE at cycle n SHALL give grant at n+1, ready at n+1 if valid is still high, and tx_start at n+2.
REQ-023 WAIT_BUSY SHALL advance to WAIT_DONE when tx_busy=1.
REQ-024 WAIT_DONE SHALL advance when tx_busy=0: to IDLE with grant=00 and the pointer flipped if the latched last=1, else back to LOAD.
REQ-025 A 22-bit timeout counter SHALL clear on every state entry and count in LOAD (no granted valid) and in WAIT_BUSY.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse timeout_err for 1 cycle, clear grant, flip the pointer and enter IDLE.
REQ-027 The timeout counter SHALL saturate and never wrap.
REQ-028 tx_data SHALL hold its last value until the next accept.
REQ-029 A packet of one byte with last=1 SHALL be legal.
REQ-030 The owner dropping valid mid-packet SHALL hold grant; it is not a release.
REQ-031 A requester raising valid during WAIT_DONE of the other's final byte SHALL be granted on the cycle after IDLE entry.

Reset
REQ-032 On rst_n=0, the block SHALL immediately clear: state=IDLE, pointer=req0, counter=0.
REQ-033 On rst_n=0, the block SHALL immediately drive to 0: grant, tx_start, req0_ready, req1_ready, timeout_err and busy.
REQ-034 On rst_n=0, tx_data SHALL reset to 0x00.
REQ-035 Reset asserted mid-packet SHALL abort that packet silently, with no timeout_err.
REQ-036 Reset release SHALL be synchronised externally, and the block SHALL act on the first edge with rst_n=1.

Verification
REQ-037 Single packet: req0 sends 0x41 then 0x42 (last), with a stub busy of 10 cycles -> two tx_start pulses, tx_data 0x41 then 0x42, grant=01 throughout, then 00.
REQ-038 Collision: req0 and req1 valid in the same IDLE cycle after reset -> req0 served first, then req1; repeat -> req1 served first.
REQ-039 Packet lock: req1 valid during req0's 3-byte packet -> req1_ready stays 0 until req0's last byte completes; req1 is granted 1 cycle after IDLE.
REQ-040 Timeout: TIMEOUT_CYCLES=16, req0 sends a non-last byte and then drops valid -> timeout_err pulses once 16 cycles into LOAD, grant=00, pointer favours req1.
REQ-041 Stuck transmitter: tx_busy held 0 after tx_start -> timeout_err after TIMEOUT_CYCLES in WAIT_BUSY, return to IDLE.
REQ-042 Reset in WAIT_DONE -> all outputs 0 the same cycle, no tx_start, next packet starts with req0 priority.
